// File: rtl/snake_dir_ctrl.sv
// Direction controller: synchronises and debounces the IR direction, queues legal turns
// and applies one per step. Define SNAKE_DIR_STATS_EN to add rej_count/last_rej outputs.
module snake_dir_ctrl #(
   parameter int         SYNC_STAGES   = 2,
   parameter int         STABLE_CYCLES = 1024,
   parameter int         QUEUE_DEPTH   = 2,
   parameter logic [1:0] INIT_DIR      = 2'd3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] ir_dir,
   input  logic       step,
   input  logic       game_rst,
   output logic [1:0] cur_dir,
   output logic       dir_changed,
`ifdef SNAKE_DIR_STATS_EN
   output logic [7:0] rej_count,
   output logic [1:0] last_rej,
`endif
   output logic       queue_full
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int AW    = $clog2(QUEUE_DEPTH);
   localparam int PW    = AW + 1;
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

   logic [1:0]       sync_r [SYNC_STAGES];
   logic [1:0]       sync_out_s;
   logic [1:0]       cand_r;
   logic [CNT_W-1:0] cnt_r;
   logic             accept_s;

   logic [1:0]       mem_r [QUEUE_DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [AW-1:0]    tail_idx_s;
   logic             empty_s;
   logic             full_s;
   logic [1:0]       ref_s;
   logic             same_s;
   logic             opp_s;
   logic             push_s;
   logic             pop_s;
   logic             rej_s;
   logic [1:0]       cur_dir_r;
   logic             dir_changed_r;

   assign sync_out_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous IR direction bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 2'd0;
      end else begin
         sync_r[0] <= ir_dir;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   // Stability filter: a saturated counter means the candidate was already consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_r <= 2'd0;
         cnt_r  <= CNT_SAT;
      end else if (game_rst) begin
         cand_r <= sync_out_s;
         cnt_r  <= CNT_SAT;
      end else if (sync_out_s != cand_r) begin
         cand_r <= sync_out_s;
         cnt_r  <= CNT_W'(0);
      end else if (cnt_r != CNT_SAT) begin
         cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r  <= cnt_r;
      end
   end

   assign accept_s   = !game_rst && (sync_out_s == cand_r) && (cnt_r == CNT_ARM);
   assign empty_s    = (wr_ptr_r == rd_ptr_r);
   assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign tail_idx_s = wr_ptr_r[AW-1:0] - AW'(1);
   assign queue_full = full_s;

   // Turn legality against the most recent heading (queued tail or applied one).
   always_comb begin
      ref_s  = cur_dir_r;
      same_s = 1'b0;
      opp_s  = 1'b0;
      push_s = 1'b0;
      rej_s  = 1'b0;
      pop_s  = 1'b0;
      if (!empty_s) begin
         ref_s = mem_r[tail_idx_s];
      end else begin
         ref_s = cur_dir_r;
      end
      same_s = (cand_r == ref_s);
      opp_s  = (cand_r[1] == ref_s[1]) && (cand_r[0] != ref_s[0]);
      if (accept_s && !same_s) begin
         push_s = !opp_s && !full_s;
         rej_s  = opp_s || full_s;
      end else begin
         push_s = 1'b0;
         rej_s  = 1'b0;
      end
      pop_s = step && !empty_s && !game_rst;
   end

   // Turn FIFO and applied heading; a same-cycle push never bypasses to cur_dir.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) mem_r[i] <= 2'd0;
         wr_ptr_r      <= PW'(0);
         rd_ptr_r      <= PW'(0);
         cur_dir_r     <= INIT_DIR;
         dir_changed_r <= 1'b0;
      end else if (game_rst) begin
         wr_ptr_r      <= PW'(0);
         rd_ptr_r      <= PW'(0);
         cur_dir_r     <= INIT_DIR;
         dir_changed_r <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= cand_r;
            wr_ptr_r                <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            cur_dir_r <= mem_r[rd_ptr_r[AW-1:0]];
            rd_ptr_r  <= rd_ptr_r + PW'(1);
         end
         dir_changed_r <= pop_s;
      end
   end

   assign cur_dir     = cur_dir_r;
   assign dir_changed = dir_changed_r;

`ifdef SNAKE_DIR_STATS_EN
   logic [7:0] rej_count_r;
   logic [1:0] last_rej_r;

   // Rejection statistics, saturating at 255.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rej_count_r <= 8'd0;
         last_rej_r  <= 2'd0;
      end else if (game_rst) begin
         rej_count_r <= 8'd0;
         last_rej_r  <= 2'd0;
      end else if (rej_s) begin
         rej_count_r <= (rej_count_r == 8'd255) ? rej_count_r : rej_count_r + 8'd1;
         last_rej_r  <= cand_r;
      end else begin
         rej_count_r <= rej_count_r;
         last_rej_r  <= last_rej_r;
      end
   end

   assign rej_count = rej_count_r;
   assign last_rej  = last_rej_r;
`endif

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: expected heading changes are queued by the
// stimulus and consumed by a monitor on every dir_changed pulse.
module tb_snake_dir_ctrl;

   logic       clk;
   logic       reset_n;
   logic [1:0] ir_dir;
   logic       step;
   logic       game_rst;
   logic [1:0] cur_dir;
   logic       dir_changed;
   logic       queue_full;
`ifdef SNAKE_DIR_STATS_EN
   logic [7:0] rej_count;
   logic [1:0] last_rej;
`endif

   int total = 0;
   int bad   = 0;
   logic [1:0] exp_q[$];

   snake_dir_ctrl #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(8),
      .QUEUE_DEPTH  (2),
      .INIT_DIR     (2'd3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ir_dir     (ir_dir),
      .step       (step),
      .game_rst   (game_rst),
      .cur_dir    (cur_dir),
      .dir_changed(dir_changed),
`ifdef SNAKE_DIR_STATS_EN
      .rej_count  (rej_count),
      .last_rej   (last_rej),
`endif
      .queue_full (queue_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every pulse must match the next expected heading.
   always @(negedge clk) begin
      if (reset_n && dir_changed) begin
         if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
         else check("pulse_dir", int'(cur_dir), int'(exp_q.pop_front()));
      end
   end

   task automatic hold(input logic [1:0] d, input int n);
      ir_dir = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_step(input bit chg, input logic [1:0] exp);
      if (chg) exp_q.push_back(exp);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      check("cur_dir_after_step", int'(cur_dir), int'(exp));
   endtask

   task automatic pulse_game_rst();
      game_rst = 1'b1;
      @(negedge clk);
      game_rst = 1'b0;
      @(negedge clk);
   endtask

   // Load a new held direction into the filter without queueing it.
   task automatic park(input logic [1:0] d);
      ir_dir = d;
      repeat (4) @(negedge clk);
      pulse_game_rst();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      ir_dir   = 2'd0;
      step     = 1'b0;
      game_rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cur_dir", int'(cur_dir), 3);
      check("rst_dir_changed", int'(dir_changed), 0);
      check("rst_queue_full", int'(queue_full), 0);
      reset_n = 1'b1;

      // Power-up value 'up' held: never queued.
      for (int i = 0; i < 10; i++) begin
         repeat (18) @(negedge clk);
         do_step(1'b0, 2'd3);
      end

      // Valid turn down, then a step with nothing queued.
      hold(2'd1, 20);
      do_step(1'b1, 2'd1);
      repeat (5) @(negedge clk);
      do_step(1'b0, 2'd1);

      // Reversal right -> left is rejected.
      pulse_game_rst();
      check("grst_cur_dir", int'(cur_dir), 3);
      check("grst_queue_full", int'(queue_full), 0);
      hold(2'd2, 20);
      do_step(1'b0, 2'd3);
`ifdef SNAKE_DIR_STATS_EN
      check("rev_rej_count", int'(rej_count), 1);
      check("rev_last_rej", int'(last_rej), 2);
`endif

      // Glitch of 'down' shorter than the filter window.
      park(2'd0);
      hold(2'd1, 5);
      hold(2'd0, 3);
      do_step(1'b0, 2'd3);
      check("glitch_queue_full", int'(queue_full), 0);
      pulse_game_rst();
      repeat (20) @(negedge clk);
      do_step(1'b0, 2'd3);

      // Fill the queue, overflow, then drain.
      park(2'd1);
      hold(2'd0, 20);
      check("q1_queue_full", int'(queue_full), 0);
      hold(2'd2, 20);
      check("q2_queue_full", int'(queue_full), 1);
      hold(2'd0, 20);
      check("q3_queue_full", int'(queue_full), 1);
`ifdef SNAKE_DIR_STATS_EN
      check("drop_rej_count", int'(rej_count), 1);
      check("drop_last_rej", int'(last_rej), 0);
`endif
      do_step(1'b1, 2'd0);
      check("drain_queue_full", int'(queue_full), 0);
      do_step(1'b1, 2'd2);
      do_step(1'b0, 2'd2);

      // Accept coinciding with a step on an empty queue: no bypass.
      park(2'd1);
      ir_dir = 2'd0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      check("coinc_cur_dir", int'(cur_dir), 3);
      check("coinc_queue_full", int'(queue_full), 0);
      do_step(1'b1, 2'd0);

      // game_rst with a full queue and a held command.
      hold(2'd2, 20);
      hold(2'd1, 20);
      check("pre_grst_full", int'(queue_full), 1);
      pulse_game_rst();
      check("post_grst_full", int'(queue_full), 0);
      check("post_grst_cur_dir", int'(cur_dir), 3);
`ifdef SNAKE_DIR_STATS_EN
      check("post_grst_rej_count", int'(rej_count), 0);
`endif
      repeat (30) @(negedge clk);
      do_step(1'b0, 2'd3);

      repeat (3) @(negedge clk);
      check("pending_expected", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
